// File: rtl/cic_offset_pkg.sv
// Shared constants and types for the CIC offset controller; ROM_LAT is also
// consumed by the offset ROM generator so both sides agree on read latency.
package cic_offset_pkg;

    localparam int IW         = 5;
    localparam int M_LOG2     = 8;
    localparam int ROM_LAT    = 3;
    localparam int FIFO_DEPTH = 8;

    localparam int ADDR_W = M_LOG2 + 1;
    localparam int OW     = IW + 1;
    localparam int M      = 1 << M_LOG2;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int IF_W   = $clog2(ROM_LAT + 2);

    localparam logic [M_LOG2-1:0] CHAN_LAST = {M_LOG2{1'b1}};

    typedef struct packed {
        logic [OW-1:0]     data;
        logic [M_LOG2-1:0] chan;
        logic              last;
    } fifo_entry_t;

    typedef struct packed {
        logic [IW-1:0]     data;
        logic [M_LOG2-1:0] chan;
        logic              last;
    } stage_t;

    // One extra result bit absorbs the carry, so the sum never wraps.
    function automatic logic [OW-1:0] add_offset(input logic [IW-1:0] sample,
                                                 input logic          offset);
        return {sample[IW-1], sample} + {{IW{1'b0}}, offset};
    endfunction

endpackage

// File: rtl/cic_offset_fifo.sv
// Small synchronous FIFO for offset-corrected samples; the head entry is
// presented combinationally from the storage registers.
module cic_offset_fifo
    import cic_offset_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  fifo_entry_t            wr_data,
    input  logic                   rd_en,
    output fifo_entry_t            rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int C_W   = PTR_W + 1;

    fifo_entry_t      mem_q [DEPTH];
    fifo_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_W-1:0]   count_q, count_d;
    logic             do_wr_s;
    logic             do_rd_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_wr_s  = wr_en && (count_q != C_W'(DEPTH));
        do_rd_s  = rd_en && (count_q != {C_W{1'b0}});

        if (do_wr_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({do_wr_s, do_rd_s})
            2'b10:   count_d = count_q + C_W'(1);
            2'b01:   count_d = count_q - C_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; contents cleared so the head reads zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {C_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/cic_offset_ctrl.sv
// Sequencer and offset adder ahead of the CIC offset ROM: issues {phase, chan}
// addresses, aligns each sample with the ROM's fixed-latency bit and buffers the sum.
module cic_offset_ctrl
    import cic_offset_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              s_axis_tvalid,
    input  logic [IW-1:0]     s_axis_tdata,
    output logic              s_axis_tready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic              m_axis_tvalid,
    output logic [OW-1:0]     m_axis_tdata,
    output logic [M_LOG2-1:0] m_axis_tuser,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    logic [M_LOG2-1:0]     chan_q, chan_d;
    logic                  phase_q, phase_d;
    logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
    logic                  s_ready_q, s_ready_d;
    stage_t [ROM_LAT:0]    dl_q, dl_d;
    logic [ROM_LAT:0]      dl_vld_q, dl_vld_d;
    logic [IF_W-1:0]       inflight_q, inflight_d;

    logic                  accept_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    fifo_entry_t           wr_entry_s;
    fifo_entry_t           head_s;
    logic [CNT_W-1:0]      fifo_cnt_s;
    logic [CNT_W-1:0]      fifo_cnt_nxt_s;
    logic [CNT_W:0]        occ_nxt_s;

    assign accept_s = s_axis_tvalid && s_ready_q;
    assign wr_en_s  = dl_vld_q[ROM_LAT];
    assign rd_en_s  = m_axis_tvalid && m_axis_tready;

    // Channel/phase sequencing and ROM address issue on each accepted sample.
    always_comb begin
        chan_d     = chan_q;
        phase_d    = phase_q;
        rom_addr_d = rom_addr_q;
        if (accept_s) begin
            rom_addr_d = {phase_q, chan_q};
            if (chan_q == CHAN_LAST) begin
                chan_d  = {M_LOG2{1'b0}};
                phase_d = ~phase_q;
            end else begin
                chan_d  = chan_q + M_LOG2'(1);
                phase_d = phase_q;
            end
        end else begin
            rom_addr_d = rom_addr_q;
        end
    end

    // Delay line: the sample travels alongside its ROM read so both arrive together.
    always_comb begin
        dl_d     = dl_q;
        dl_vld_d = {dl_vld_q[ROM_LAT-1:0], accept_s};
        for (int i = 1; i <= ROM_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
        if (accept_s) begin
            dl_d[0] = '{data: s_axis_tdata, chan: chan_q, last: (chan_q == CHAN_LAST)};
        end else begin
            dl_d[0] = dl_q[0];
        end
    end

    // Result assembled from the aligned stage and the returned offset bit.
    always_comb begin
        wr_entry_s      = '0;
        wr_entry_s.data = add_offset(dl_q[ROM_LAT].data, rom_data);
        wr_entry_s.chan = dl_q[ROM_LAT].chan;
        wr_entry_s.last = dl_q[ROM_LAT].last;
    end

    // Credit accounting: the ROM pipe cannot stall, so ready reserves a FIFO slot
    // for every sample already in flight.
    always_comb begin
        inflight_d     = inflight_q;
        fifo_cnt_nxt_s = fifo_cnt_s;
        case ({accept_s, wr_en_s})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({wr_en_s, rd_en_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_s + CNT_W'(1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_s - CNT_W'(1);
            default: fifo_cnt_nxt_s = fifo_cnt_s;
        endcase
        occ_nxt_s = {1'b0, fifo_cnt_nxt_s} + (CNT_W+1)'(inflight_d);
        s_ready_d = (occ_nxt_s < (CNT_W+1)'(FIFO_DEPTH));
    end

    // Control and alignment registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q     <= {M_LOG2{1'b0}};
            phase_q    <= 1'b0;
            rom_addr_q <= {ADDR_W{1'b0}};
            s_ready_q  <= 1'b0;
            dl_q       <= '0;
            dl_vld_q   <= {(ROM_LAT+1){1'b0}};
            inflight_q <= {IF_W{1'b0}};
        end else begin
            chan_q     <= chan_d;
            phase_q    <= phase_d;
            rom_addr_q <= rom_addr_d;
            s_ready_q  <= s_ready_d;
            dl_q       <= dl_d;
            dl_vld_q   <= dl_vld_d;
            inflight_q <= inflight_d;
        end
    end

    cic_offset_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_data (wr_entry_s),
        .rd_en   (rd_en_s),
        .rd_data (head_s),
        .count   (fifo_cnt_s)
    );

    assign s_axis_tready = s_ready_q;
    assign rom_addr      = rom_addr_q;
    assign m_axis_tvalid = (fifo_cnt_s != {CNT_W{1'b0}});
    assign m_axis_tdata  = head_s.data;
    assign m_axis_tuser  = head_s.chan;
    assign m_axis_tlast  = head_s.last;

endmodule

// File: tb/tb_cic_offset_ctrl.sv
// Randomized bench for cic_offset_ctrl: a ROM model with fixed latency plus an
// arithmetic reference (sample index -> channel/phase -> offset) and output queue.
module tb_cic_offset_ctrl;
    import cic_offset_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_axis_tvalid;
    logic [IW-1:0]     s_axis_tdata;
    logic              s_axis_tready;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_data;
    logic              m_axis_tvalid;
    logic [OW-1:0]     m_axis_tdata;
    logic [M_LOG2-1:0] m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tready;

    cic_offset_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    // Offset ROM: registers the address, then ROM_LAT-1 more output stages.
    bit                 rom_tbl [0:2*M-1];
    logic [ROM_LAT-1:0] rom_pipe = '0;
    always @(posedge clk) rom_pipe <= {rom_pipe[ROM_LAT-2:0], rom_tbl[rom_addr]};
    assign rom_data = rom_pipe[ROM_LAT-1];

    typedef struct {
        int data;
        int chan;
        int last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   cyc = 0;
    bit   hold = 0;
    bit   rom_chk_pend = 0;
    int   rom_exp = 0;
    bit   lat_armed = 0;
    int   first_acc = -1;
    int   first_vld = -1;
    bit   sat_toggle = 0;
    bit   first_after_rst = 0;
    int   prev_out = 0;
    int   last_out = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_rom(input int fill);
        for (int a = 0; a < 2*M; a++) rom_tbl[a] = fill[0];
    endtask

    // One clock: drive at negedge, observe handshakes, update the reference.
    task automatic tick(input int vp, input int rp, input int dmode);
        bit   acc;
        bit   outx;
        int   ch;
        int   ph;
        int   addr;
        int   sv;
        exp_t e;
        @(negedge clk);
        if (rom_chk_pend) begin
            chk("rom_addr", rom_addr, rom_exp);
            rom_chk_pend = 0;
        end
        if (!hold) begin
            s_axis_tvalid = ($urandom_range(99) < vp);
            case (dmode)
                0:       s_axis_tdata = IW'((n_acc % M) - 16);
                2:       s_axis_tdata = sat_toggle ? 5'b10000 : 5'b01111;
                default: s_axis_tdata = IW'($urandom);
            endcase
        end
        m_axis_tready = ($urandom_range(99) < rp);
        #1;
        acc  = s_axis_tvalid && s_axis_tready;
        outx = m_axis_tvalid && m_axis_tready;
        chk("occupancy", ((n_acc - n_out) <= FIFO_DEPTH), 1);
        if (lat_armed) begin
            if (acc && first_acc < 0) first_acc = cyc;
            if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
        end
        if (q.size() == 0) begin
            chk("valid_when_empty", m_axis_tvalid, 0);
        end else if (outx) begin
            e = q.pop_front();
            chk("tdata", m_axis_tdata, e.data);
            chk("tuser", m_axis_tuser, e.chan);
            chk("tlast", m_axis_tlast, e.last);
            if (first_after_rst) begin
                chk("rst_first_tuser", m_axis_tuser, 0);
                first_after_rst = 0;
            end
            prev_out = last_out;
            last_out = m_axis_tdata;
            n_out++;
        end
        if (acc) begin
            ch   = n_acc % M;
            ph   = (n_acc / M) % 2;
            addr = ph * M + ch;
            sv   = $signed(s_axis_tdata);
            e.data = (sv + int'(rom_tbl[addr])) & ((1 << OW) - 1);
            e.chan = ch;
            e.last = (ch == M - 1);
            q.push_back(e);
            rom_exp      = addr;
            rom_chk_pend = 1;
            n_acc++;
            if (dmode == 2) sat_toggle = ~sat_toggle;
        end
        hold = s_axis_tvalid && !acc;
        cyc++;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0 || hold) && guard < 400) begin
            tick(0, 100, 1);
            guard++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sready"}, s_axis_tready, 0);
        chk({tag, "_romaddr"}, rom_addr, 0);
        chk({tag, "_mvalid"}, m_axis_tvalid, 0);
        chk({tag, "_mdata"}, m_axis_tdata, 0);
        chk({tag, "_muser"}, m_axis_tuser, 0);
        chk({tag, "_mlast"}, m_axis_tlast, 0);
    endtask

    initial begin
        int base;
        int guard;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        set_rom(0);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", s_axis_tready, 1);

        // Zero ROM, two full frames back to back; accept-to-valid spans E0..E4.
        lat_armed = 1;
        base = n_acc;
        repeat (2 * M) tick(100, 100, 0);
        chk("t1_no_bubbles", n_acc - base, 2 * M);
        drain();
        chk("t1_latency", first_vld - first_acc, 5);
        lat_armed = 0;

        // Offsets only at address 5 (phase 0) and 261 (phase 1).
        set_rom(0);
        rom_tbl[5]   = 1'b1;
        rom_tbl[261] = 1'b1;
        repeat (2 * M) tick(100, 100, 1);
        drain();

        // Extremes of the input range with offset 1.
        set_rom(1);
        sat_toggle = 0;
        base  = n_acc;
        guard = 0;
        while (n_acc - base < 2 && guard < 50) begin
            tick(100, 100, 2);
            guard++;
        end
        drain();
        chk("sat_pos", prev_out, 6'b010000);
        chk("sat_neg", last_out, 6'b110001);

        // Downstream stalled with continuous input.
        set_rom(0);
        base = n_acc;
        repeat (20) tick(100, 0, 1);
        chk("stall_accepts", n_acc - base, FIFO_DEPTH);
        chk("stall_ready", s_axis_tready, 0);
        drain();

        // Random traffic on both sides.
        rom_tbl[37]  = 1'b1;
        rom_tbl[300] = 1'b1;
        rom_tbl[511] = 1'b1;
        base  = n_acc;
        guard = 0;
        while (n_acc - base < 10000 && guard < 60000) begin
            tick(50, 50, 1);
            guard++;
        end
        chk("rand_count", n_acc - base, 10000);
        drain();

        // Park in frame 1 mid-frame, then reset with 4 buffered and 3 in flight.
        set_rom(0);
        rom_tbl[0] = 1'b1;
        guard = 0;
        while ((n_acc % (2 * M)) != 300 && guard < 2000) begin
            tick(100, 100, 1);
            guard++;
        end
        drain();
        base = n_acc;
        guard = 0;
        while (n_acc - base < 7 && guard < 50) begin
            tick(100, 0, 1);
            guard++;
        end
        tick(0, 0, 1);
        @(negedge clk);
        chk("pre_reset_valid", m_axis_tvalid, 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        n_acc = 0;
        n_out = 0;
        hold = 0;
        rom_chk_pend = 0;
        first_after_rst = 1;
        tick(0, 100, 1);
        repeat (8) tick(100, 100, 1);
        drain();
        chk("rst_first_seen", first_after_rst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
